// File: rtl/pair_exit_fifo_mc_if.sv
// Bus bundle for pair_exit_fifo_mc: the lane inputs, the host read level,
// the readback outputs and a phase debug tap.
//
// Handshake: in_valid is a per-lane qualifier with no ready. The block
// samples every lane on every clock and never back-pressures. An entry
// that arrives while the FIFO is full is dropped. rd_req is a host level,
// not a valid/ready pair. Only its rising edge, sampled on the slot-boundary
// cycle, pops one entry. out_valid qualifies out_data/out_mask until the
// next boundary edge.
interface pair_exit_fifo_mc_if #(
    parameter int LANES = 2,
    parameter int REC_W = 97,
    parameter int CNT_W = 32,
    parameter int SLOT  = 16
);
    localparam int PH_W = $clog2(SLOT);

    logic [LANES*REC_W-1:0] in_data;
    logic [LANES-1:0]       in_valid;
    logic                   rd_req;
    logic [LANES*REC_W-1:0] out_data;
    logic [LANES-1:0]       out_mask;
    logic                   out_valid;
    logic [7:0]             out_seq;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic [CNT_W-1:0]       drop_count;
    logic [PH_W-1:0]        dbg_phase;

    // Producer/host side.
    modport master (
        output in_data, in_valid, rd_req,
        input  out_data, out_mask, out_valid, out_seq, count, full,
               drop_count, dbg_phase
    );

    // FIFO side.
    modport slave (
        input  in_data, in_valid, rd_req,
        output out_data, out_mask, out_valid, out_seq, count, full,
               drop_count, dbg_phase
    );
endinterface

// File: rtl/pair_exit_fifo_mc.sv
// pair_exit_fifo_mc: multi-lane pair-record exit FIFO.
//
// Each cycle in the write window, one entry of LANES records is captured
// with its keep mask. Null-sentinel and invalid lanes are masked. Entries
// are released one per rising edge of the host read level, and that edge
// is sampled only on the slot-boundary cycle.
//
// Optional build macro PAIR_EXIT_DROP_CNT_EN enables the saturating
// overflow drop counter. Without it, drop_count is tied to zero and overflow
// entries are still discarded silently.
module pair_exit_fifo_mc #(
    parameter int LANES = 2,
    parameter int REC_W = 97,
    parameter int DEPTH = 256,
    parameter int SLOT  = 16,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    pair_exit_fifo_mc_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PH_W   = $clog2(SLOT);
    localparam int DATA_W = LANES * REC_W;
    localparam int ENT_W  = DATA_W + LANES;

    localparam logic [REC_W-1:0] NULL_REC = {1'b1, {(REC_W-1){1'b0}}};
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SLOT - 1);
    localparam logic [PH_W-1:0]  PH_BLIND = PH_W'(SLOT - 2);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    // Slot phase; the last two phases are write-blind and the last is the read boundary.
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    // Occupancy is kept separately from the pointers so full and empty never alias.
    logic [PTR_W:0]    count_q, count_d;
    logic              host_prev_q, host_prev_d;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]  out_mask_q, out_mask_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_seq_q, out_seq_d;

    // Native storage: entry = {keep mask, raw lane data}.
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  head;

    logic [LANES-1:0]  keep;
    logic              boundary;
    logic              write_window;
    logic              wr_req;
    logic              wr_acc;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rd_edge;
    logic              pop;

    // Per-lane keep: the lane must be valid and must not carry the null sentinel.
    always_comb begin
        keep = '0;
        for (int i = 0; i < LANES; i++) begin
            keep[i] = bus.in_valid[i] && (bus.in_data[i*REC_W +: REC_W] != NULL_REC);
        end
    end

    assign boundary     = (phase_q == PH_LAST);
    assign write_window = (phase_q < PH_BLIND);
    assign wr_req       = write_window && (|keep);
    assign fifo_full    = (count_q == CNT_FULL);
    assign fifo_empty   = (count_q == '0);
    assign wr_acc       = wr_req && !fifo_full;
    assign rd_edge      = boundary && bus.rd_req && !host_prev_q;
    assign pop          = rd_edge && !fifo_empty;
    assign head         = mem[rd_ptr_q];

    // Next-state for the phase, pointers, occupancy and host edge detector.
    always_comb begin
        phase_d     = phase_q + 1'b1;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        host_prev_d = host_prev_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Writes and pops fall in disjoint phases, so at most one of these is set.
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (boundary) begin
            host_prev_d = bus.rd_req;
        end
    end

    // Next-state for the readback registers; they change only on a boundary edge.
    always_comb begin
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        out_valid_d = out_valid_q;
        out_seq_d   = out_seq_q;
        if (rd_edge) begin
            if (pop) begin
                out_data_d  = head[DATA_W-1:0];
                out_mask_d  = head[ENT_W-1:DATA_W];
                out_valid_d = 1'b1;
                out_seq_d   = out_seq_q + 8'd1;
            end else begin
                out_data_d  = '0;
                out_mask_d  = '0;
                out_valid_d = 1'b0;
            end
        end
    end

    // Control and readback state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_LAST;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            host_prev_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
            out_seq_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            host_prev_q <= host_prev_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            out_valid_q <= out_valid_d;
            out_seq_q   <= out_seq_d;
        end
    end

    // Entry storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q] <= {keep, bus.in_data};
        end
    end

`ifdef PAIR_EXIT_DROP_CNT_EN
    logic             wr_drop;
    logic [CNT_W-1:0] drop_q;

    assign wr_drop = wr_req && fifo_full;

    // Saturating count of entries lost because the FIFO was full.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (wr_drop && (drop_q != {CNT_W{1'b1}})) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign bus.drop_count = drop_q;
`else
    assign bus.drop_count = '0;
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_seq   = out_seq_q;
    assign bus.count     = {{(CNT_W-PTR_W-1){1'b0}}, count_q};
    assign bus.full      = fifo_full;
    assign bus.dbg_phase = phase_q;

endmodule

// File: tb/tb_pair_exit_fifo_mc.sv
// Self-checking bench for pair_exit_fifo_mc (LANES=2, REC_W=97, DEPTH=16, SLOT=16).
// The reference model keeps the FIFO as a queue of {mask, data} entries and
// applies the slot, keep, overflow and read-edge rules once per clock.
module tb_pair_exit_fifo_mc;
    localparam int LANES  = 2;
    localparam int REC_W  = 97;
    localparam int DEPTH  = 16;
    localparam int SLOT   = 16;
    localparam int CNT_W  = 32;
    localparam int DATA_W = LANES * REC_W;
    localparam int ENT_W  = DATA_W + LANES;
    localparam logic [REC_W-1:0] NULL_REC = {1'b1, {(REC_W-1){1'b0}}};

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pair_exit_fifo_mc_if #(.LANES(LANES), .REC_W(REC_W), .CNT_W(CNT_W), .SLOT(SLOT)) bus ();

    pair_exit_fifo_mc #(
        .LANES(LANES), .REC_W(REC_W), .DEPTH(DEPTH), .SLOT(SLOT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard / model ----------------
    logic [ENT_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] m_data;
    logic [LANES-1:0]  m_mask;
    logic              m_valid;
    int                m_seq;
    int                m_drop;
    bit                m_prev;
    int                m_phase;

    int n_checks;
    int n_fail;

    function automatic logic [REC_W-1:0] rand_rec(bit allow_null);
        logic [127:0]     w;
        logic [REC_W-1:0] r;
        w = {$urandom, $urandom, $urandom, $urandom};
        r = w[REC_W-1:0];
        if (allow_null) begin
            if ($urandom_range(0, 3) == 0) r = NULL_REC;
        end else begin
            r[0] = 1'b1;
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one clock, applying the model rules to the inputs held this cycle.
    task automatic tick();
        logic [LANES-1:0] keep;
        logic [ENT_W-1:0] e;
        keep = '0;
        if (reset) begin
            @(posedge clk);
            #1;
            exp_q.delete();
            m_data  = '0;
            m_mask  = '0;
            m_valid = 1'b0;
            m_seq   = 0;
            m_drop  = 0;
            m_prev  = 1'b0;
            m_phase = SLOT - 1;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                keep[i] = bus.in_valid[i] && (bus.in_data[i*REC_W +: REC_W] !== NULL_REC);
            end
            if (m_phase < SLOT - 2 && keep != '0) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back({keep, bus.in_data});
                end else begin
`ifdef PAIR_EXIT_DROP_CNT_EN
                    m_drop = m_drop + 1;
`endif
                end
            end
            if (m_phase == SLOT - 1) begin
                if (bus.rd_req && !m_prev) begin
                    if (exp_q.size() != 0) begin
                        e       = exp_q.pop_front();
                        m_data  = e[DATA_W-1:0];
                        m_mask  = e[ENT_W-1:DATA_W];
                        m_valid = 1'b1;
                        m_seq   = (m_seq + 1) % 256;
                    end else begin
                        m_data  = '0;
                        m_mask  = '0;
                        m_valid = 1'b0;
                    end
                end
                m_prev = bus.rd_req;
            end
            @(posedge clk);
            #1;
            m_phase = (m_phase + 1) % SLOT;
        end
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic go_to_phase(int p);
        for (int k = 0; k < SLOT && m_phase != p; k++) tick();
    endtask

    // One host read: level high for a full slot, then low for a full slot.
    task automatic do_read();
        bus.rd_req = 1'b1;
        ticks(SLOT);
        bus.rd_req = 1'b0;
        ticks(SLOT);
    endtask

    // Write n entries of non-null records in write phases only.
    task automatic write_entries(int n);
        int w;
        w = 0;
        while (w < n) begin
            if (m_phase < SLOT - 2) begin
                bus.in_data  = {rand_rec(1'b0), rand_rec(1'b0)};
                bus.in_valid = LANES'($urandom_range(1, 3));
                w++;
            end else begin
                bus.in_valid = '0;
            end
            tick();
        end
        bus.in_valid = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        ticks(40);
        n_checks++; if (bus.count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_seq !== 8'd0) begin n_fail++; $display("FAIL reset_out_seq: got %0d want 0", bus.out_seq); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        n_checks++; if (bus.drop_count !== 32'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
        n_checks++; if (bus.dbg_phase !== 4'(m_phase)) begin n_fail++; $display("FAIL reset_phase: got %0d want %0d", bus.dbg_phase, m_phase); end
    endtask

    task automatic test_single_pop();
        logic [DATA_W-1:0] want;
        go_to_phase(3);
        bus.in_data  = {NULL_REC, 97'h5};
        bus.in_valid = 2'b01;
        tick();
        bus.in_valid = '0;
        n_checks++; if (bus.count !== 32'd1) begin n_fail++; $display("FAIL single_count_after_write: got %0d want 1", bus.count); end
        bus.rd_req = 1'b1;
        ticks(SLOT);
        want = {NULL_REC, 97'h5};
        n_checks++; if (bus.out_data !== want) begin n_fail++; $display("FAIL single_out_data: got %h want %h", bus.out_data, want); end
        n_checks++; if (bus.out_mask !== 2'b01) begin n_fail++; $display("FAIL single_out_mask: got %b want 01", bus.out_mask); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_seq !== 8'd1) begin n_fail++; $display("FAIL single_out_seq: got %0d want 1", bus.out_seq); end
        n_checks++; if (bus.count !== 32'd0) begin n_fail++; $display("FAIL single_count_after_pop: got %0d want 0", bus.count); end
        bus.rd_req = 1'b0;
        ticks(SLOT);
    endtask

    task automatic test_null_blind();
        go_to_phase(2);
        bus.in_data  = {NULL_REC, NULL_REC};
        bus.in_valid = 2'b11;
        tick();
        bus.in_valid = '0;
        go_to_phase(14);
        bus.in_data  = {rand_rec(1'b0), 97'h1234};
        bus.in_valid = 2'b11;
        ticks(2);
        bus.in_valid = '0;
        tick();
        n_checks++; if (bus.count !== 32'd0) begin n_fail++; $display("FAIL null_blind_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.drop_count !== 32'd0) begin n_fail++; $display("FAIL null_blind_drop: got %0d want 0", bus.drop_count); end
    endtask

    task automatic test_overflow();
        int want_drop;
`ifdef PAIR_EXIT_DROP_CNT_EN
        want_drop = 4;
`else
        want_drop = 0;
`endif
        bus.rd_req = 1'b0;
        write_entries(20);
        n_checks++; if (bus.count !== 32'd16) begin n_fail++; $display("FAIL overflow_count: got %0d want 16", bus.count); end
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL overflow_full: got %b want 1", bus.full); end
        n_checks++; if (bus.drop_count !== 32'(want_drop)) begin n_fail++; $display("FAIL overflow_drop: got %0d want %0d", bus.drop_count, want_drop); end
        // Drain down to five entries, checking each popped entry against the queue.
        for (int k = 0; k < 11; k++) begin
            do_read();
            n_checks++; if (bus.out_data !== m_data || bus.out_mask !== m_mask || bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL overflow_drain_pop%0d: got %b/%h want %b/%h", k, bus.out_mask, bus.out_data, m_mask, m_data);
            end
        end
        n_checks++; if (bus.count !== 32'd5) begin n_fail++; $display("FAIL overflow_drained_count: got %0d want 5", bus.count); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL overflow_drained_full: got %b want 0", bus.full); end
    endtask

    task automatic test_hold_read();
        int seq0;
        seq0 = m_seq;
        bus.rd_req = 1'b1;
        ticks(3 * SLOT);
        n_checks++; if (bus.count !== 32'd4) begin n_fail++; $display("FAIL hold_count: got %0d want 4", bus.count); end
        n_checks++; if (bus.out_seq !== 8'((seq0 + 1) % 256)) begin n_fail++; $display("FAIL hold_seq: got %0d want %0d", bus.out_seq, (seq0 + 1) % 256); end
        bus.rd_req = 1'b0;
        ticks(SLOT);
        bus.rd_req = 1'b1;
        ticks(SLOT);
        n_checks++; if (bus.count !== 32'd3) begin n_fail++; $display("FAIL hold_reraise_count: got %0d want 3", bus.count); end
        n_checks++; if (bus.out_seq !== 8'((seq0 + 2) % 256)) begin n_fail++; $display("FAIL hold_reraise_seq: got %0d want %0d", bus.out_seq, (seq0 + 2) % 256); end
        n_checks++; if (bus.out_data !== m_data) begin n_fail++; $display("FAIL hold_data: got %h want %h", bus.out_data, m_data); end
        bus.rd_req = 1'b0;
        ticks(SLOT);
    endtask

    task automatic test_empty_read();
        int seq0;
        for (int k = 0; k < 3; k++) do_read();
        n_checks++; if (bus.count !== 32'd0) begin n_fail++; $display("FAIL empty_drained_count: got %0d want 0", bus.count); end
        seq0 = m_seq;
        do_read();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL empty_out_data: got %h want 0", bus.out_data); end
        n_checks++; if (bus.out_mask !== 2'b00) begin n_fail++; $display("FAIL empty_out_mask: got %b want 00", bus.out_mask); end
        n_checks++; if (bus.out_seq !== 8'(seq0)) begin n_fail++; $display("FAIL empty_out_seq: got %0d want %0d", bus.out_seq, seq0); end
    endtask

    task automatic test_reset_mid();
        write_entries(7);
        n_checks++; if (bus.count !== 32'd7) begin n_fail++; $display("FAIL midreset_pre_count: got %0d want 7", bus.count); end
        reset = 1'b1;
        tick();
        n_checks++; if (bus.count !== 32'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.out_seq !== 8'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out: got seq %0d valid %b want 0 0", bus.out_seq, bus.out_valid); end
        n_checks++; if (bus.dbg_phase !== 4'(SLOT - 1)) begin n_fail++; $display("FAIL midreset_phase: got %0d want %0d", bus.dbg_phase, SLOT - 1); end
        reset = 1'b0;
        tick();
        n_checks++; if (bus.dbg_phase !== 4'd0) begin n_fail++; $display("FAIL midreset_phase_wrap: got %0d want 0", bus.dbg_phase); end
    endtask

    task automatic test_random();
        int wr_pct;
        for (int c = 0; c < 1200; c++) begin
            wr_pct = (c < 600) ? 90 : 6;
            bus.in_data  = {rand_rec(1'b1), rand_rec(1'b1)};
            bus.in_valid = ($urandom_range(0, 99) < wr_pct) ? LANES'($urandom_range(1, 3)) : '0;
            if ($urandom_range(0, 7) == 0) bus.rd_req = ~bus.rd_req;
            tick();
            n_checks++; if (bus.count !== 32'(exp_q.size())) begin n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", c, bus.count, exp_q.size()); end
            n_checks++; if (bus.full !== (exp_q.size() == DEPTH)) begin n_fail++; $display("FAIL rand_full c%0d: got %b want %b", c, bus.full, exp_q.size() == DEPTH); end
            n_checks++; if (bus.out_valid !== m_valid || bus.out_mask !== m_mask) begin n_fail++; $display("FAIL rand_valid_mask c%0d: got %b/%b want %b/%b", c, bus.out_valid, bus.out_mask, m_valid, m_mask); end
            n_checks++; if (bus.out_data !== m_data) begin n_fail++; $display("FAIL rand_data c%0d: got %h want %h", c, bus.out_data, m_data); end
            n_checks++; if (bus.out_seq !== 8'(m_seq)) begin n_fail++; $display("FAIL rand_seq c%0d: got %0d want %0d", c, bus.out_seq, m_seq); end
            n_checks++; if (bus.drop_count !== 32'(m_drop)) begin n_fail++; $display("FAIL rand_drop c%0d: got %0d want %0d", c, bus.drop_count, m_drop); end
        end
        bus.in_valid = '0;
        bus.rd_req   = 1'b0;
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.in_data  = '0;
        bus.in_valid = '0;
        bus.rd_req   = 1'b0;
        exp_q.delete();
        m_data  = '0;
        m_mask  = '0;
        m_valid = 1'b0;
        m_seq   = 0;
        m_drop  = 0;
        m_prev  = 1'b0;
        m_phase = SLOT - 1;

        test_reset();
        test_single_pop();
        test_null_blind();
        test_overflow();
        test_hold_read();
        test_empty_read();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
